exc_commit_unit: RTL
====================

# exc_commit_unit

Parametrised precise-exception commit unit for the MIPS core, placed at the memory stage next to CP0. Each cycle it prioritises the memory-stage instruction's exception flags, address errors and pending interrupts. Interrupt pins are synchronised internally. Once an exception is accepted, a small FSM owns the pipeline: a one-cycle CP0 commit pulse, a programmable pipeline flush, then a ready/valid PC-redirect handshake with the fetch stage.

## Interface
- NUM_HW_INT, 6, number of hardware interrupt pins (1..6); they map to Cause.IP[2+NUM_HW_INT-1:2] and unused IP bits read 0.
- FLUSH_CYCLES, 1, cycles `flush` stays high (1..7).
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET.
- clk  in  1  clock; the unit uses a single clock domain.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  memory-stage slot holds a real instruction.
- mem_except  in  8  flags: [7] instruction address error, [6] syscall, [5] break, [4] eret, [3] reserved instr, [2] overflow; other bits ignored.
- adel, ades  in  1 each  data load/store address error.
- mem_pc  in  32  memory-stage PC.
- mem_in_ds  in  1  instruction is in a delay slot.
- mem_badvaddr  in  32  faulting data address.
- hw_int  in  NUM_HW_INT  asynchronous interrupt pins.
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 contents.
- exc_type  out  32  combinational exception code of the current slot; reads EXC_NONE when mem_valid=0 or the FSM is not IDLE.
- hw_ip  out  NUM_HW_INT  synchronised pins, fed to Cause.IP.
- commit  out  1  one-cycle CP0 update strobe.
- commit_code  out  5  ExcCode.
- commit_epc  out  32  EPC to write.
- commit_bd  out  1  Cause.BD to write.
- commit_badv  out  32  BadVAddr to write.
- commit_eret  out  1  the commit is an ERET, so CP0 clears EXL instead of setting it.
- flush  out  1  kill all younger pipeline stages.
- busy  out  1  FSM is not in IDLE; used to stall the front end.
- redir_valid  out  1  redirect request.
- redir_pc  out  32  redirect target.
- redir_ready  in  1  fetch accepts the redirect.

## Operation
- **Codes:** EXC_NONE=0x00, INT=0x01, ADEL=0x04, ADES=0x05, SYSCALL=0x08, BREAK=0x09, RI=0x0A, OVF=0x0C, ERET=0x0E. The 32-bit exc_type zero-extends the code.
- **Priority (highest first):** mem_except[7] (ADEL, with badv=mem_pc), [2] OVF, [6] SYSCALL, [5] BREAK, [4] ERET, [3] RI, adel (badv=mem_badvaddr), ades, INT, NONE.
- **Interrupt condition:** INT requires all of:
  - (IP & Status.IM[15:8]) != 0, where IP = {hw_ip, Cause.IP[9:8]};
  - Status.EXL = 0;
  - Status.IE = 1;
  - mem_valid = 1.
- **Synchroniser:** hw_int passes through a 2-flop synchroniser per bit; hw_ip is the second flop.
- **States:**
  - IDLE: on mem_valid and exc_type != NONE, latch code, EPC, BD, badv and eret; go to FLUSH.
  - FLUSH: flush=1 for FLUSH_CYCLES cycles, counted by a 3-bit counter; commit=1 in the first FLUSH cycle only; then go to REDIR.
  - REDIR: redir_valid=1, with redir_pc = cp0_epc for ERET (sampled at acceptance) and EXC_VECTOR otherwise; on redir_valid & redir_ready go to IDLE.
- **EPC:** mem_pc - 4 when mem_in_ds=1, else mem_pc; wraps modulo 2^32. BD=mem_in_ds. ERET commits EPC/BD unchanged.
- **Busy:** busy = (state != IDLE). Inputs are ignored while busy; no second exception is accepted until the redirect handshake completes.
- **redir_pc stability:** redir_pc stays stable while redir_valid=1 and redir_ready=0.

## Timing
- **Reset:** state IDLE, synchroniser flops 0, and all registered outputs 0 (commit, flush, busy, redir_valid, commit_*, redir_pc). exc_type follows its inputs combinationally.
- **Reset mid-operation:** rst in FLUSH or REDIR returns to IDLE on the next edge; no commit and no redirect is issued afterwards.
- **Acceptance latency:** exception at edge N gives commit/flush/busy=1 in cycle N+1.
- **Redirect:** redir_valid rises in cycle N+1+FLUSH_CYCLES. With redir_ready held high, busy falls after N+1+FLUSH_CYCLES, so the minimum occupancy is FLUSH_CYCLES+1 cycles.
- **Interrupt latency:** a pin rising before edge K is visible in hw_ip after edge K+1, and is first acceptable at edge K+2.
- **Simultaneous events:** the highest priority wins. An interrupt together with a synchronous exception is not latched; it is re-evaluated after EXL handling.

## Structure
- exc_pkg holds the EXC_* codes, the state enum (IDLE, FLUSH, REDIR), the Status/Cause field bit positions and the priority order.
- One sub-module, `int_sync`: a parametrised N-bit 2-flop synchroniser with synchronous reset.

## Test plan
- **Delay-slot overflow:** mem_except[2]=1, mem_pc=0x80001008, mem_in_ds=1 → next cycle commit=1, code 0x0C, epc 0x80001004, bd=1. redir_pc=0xBFC00380 appears FLUSH_CYCLES cycles later.
- **Priority:** mem_except=0x48 with adel=1 → exc_type=0x08. mem_except=0x80 with ades=1, mem_pc=0x1 → code 0x04, badv=0x1.
- **Interrupts:** hw_int[0] rises with Status=0x0000_0401 → code 0x01 accepted 2 edges later. The same stimulus with EXL=1, or with IE=0, gives no commit.
- **ERET:** mem_except[4], cp0_epc=0x80002000 → commit_eret=1, redir_pc=0x80002000.
- **Redirect backpressure:** hold redir_ready=0 for 5 cycles → redir_valid and redir_pc stay stable, busy=1. A new mem_except during that window is ignored.
- **Reset and flush length:** rst asserted in the first FLUSH cycle with FLUSH_CYCLES=3 → all outputs 0 next cycle and redir_valid never rises. A separate case with FLUSH_CYCLES=3 shows flush high for exactly 3 cycles.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the precise-exception commit unit: exception codes,
// FSM states, CP0 field positions and the exception priority order.
package exc_pkg;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_ERET = 5'h0E;

  // CP0 Status / Cause field positions
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned CA_IP_LO = 8;
  localparam int unsigned CA_BD    = 31;

  // Bit positions inside the memory-stage exception flag byte
  localparam int unsigned FLG_IADE = 7;
  localparam int unsigned FLG_SYS  = 6;
  localparam int unsigned FLG_BRK  = 5;
  localparam int unsigned FLG_ERET = 4;
  localparam int unsigned FLG_RI   = 3;
  localparam int unsigned FLG_OV   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIR
  } state_e;

  // Highest priority first; interrupts lose to every synchronous exception.
  function automatic logic [4:0] prioritise(input logic [7:0] flags,
                                            input logic       adel,
                                            input logic       ades,
                                            input logic       int_ok);
    if (flags[FLG_IADE])      return EXC_ADEL;
    else if (flags[FLG_OV])   return EXC_OV;
    else if (flags[FLG_SYS])  return EXC_SYS;
    else if (flags[FLG_BRK])  return EXC_BP;
    else if (flags[FLG_ERET]) return EXC_ERET;
    else if (flags[FLG_RI])   return EXC_RI;
    else if (adel)            return EXC_ADEL;
    else if (ades)            return EXC_ADES;
    else if (int_ok)          return EXC_INT;
    else                      return EXC_NONE;
  endfunction

endpackage

// File: rtl/int_sync.sv
// N-bit two-flop synchroniser for asynchronous interrupt pins.
module int_sync #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/exc_commit_unit.sv
// Precise-exception commit unit: prioritises memory-stage exceptions and
// interrupts, then sequences CP0 commit, pipeline flush and PC redirect.
module exc_commit_unit
  import exc_pkg::*;
#(
  parameter int unsigned NUM_HW_INT   = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_except,
  input  logic                  adel,
  input  logic                  ades,
  input  logic [31:0]           mem_pc,
  input  logic                  mem_in_ds,
  input  logic [31:0]           mem_badvaddr,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  output logic [31:0]           exc_type,
  output logic [NUM_HW_INT-1:0] hw_ip,
  output logic                  commit,
  output logic [4:0]            commit_code,
  output logic [31:0]           commit_epc,
  output logic                  commit_bd,
  output logic [31:0]           commit_badv,
  output logic                  commit_eret,
  output logic                  flush,
  output logic                  busy,
  output logic                  redir_valid,
  output logic [31:0]           redir_pc,
  input  logic                  redir_ready
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] rpc_q, rpc_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;

  logic [7:0]  ip_vec;
  logic        int_ok;
  logic        idle;
  logic [4:0]  exc_code;
  logic        is_eret;
  logic [31:0] slot_epc;
  logic [31:0] slot_badv;

  int_sync #(.N(NUM_HW_INT)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (hw_ip)
  );

  // Software IP[1:0] come straight from Cause; pins above NUM_HW_INT read 0.
  always_comb begin
    ip_vec                = '0;
    ip_vec[1:0]           = cp0_cause[CA_IP_LO +: 2];
    ip_vec[2 +: NUM_HW_INT] = hw_ip;
  end

  assign idle   = (state_q == S_IDLE);
  assign int_ok = mem_valid && (|(ip_vec & cp0_status[ST_IM_LO +: 8]))
                  && !cp0_status[ST_EXL] && cp0_status[ST_IE];

  always_comb begin
    exc_code = EXC_NONE;
    if (mem_valid && idle) exc_code = prioritise(mem_except, adel, ades, int_ok);
  end

  assign is_eret  = (exc_code == EXC_ERET);
  assign slot_epc = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;

  always_comb begin
    slot_badv = '0;
    case (exc_code)
      EXC_ADEL: slot_badv = mem_except[FLG_IADE] ? mem_pc : mem_badvaddr;
      EXC_ADES: slot_badv = mem_badvaddr;
      default:  slot_badv = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    epc_d   = epc_q;
    badv_d  = badv_q;
    rpc_d   = rpc_q;
    bd_d    = bd_q;
    eret_d  = eret_q;
    case (state_q)
      S_IDLE: begin
        if (exc_code != EXC_NONE) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          code_d  = exc_code;
          badv_d  = slot_badv;
          eret_d  = is_eret;
          // ERET leaves EPC/BD as they are and returns to the saved EPC.
          epc_d   = is_eret ? cp0_epc : slot_epc;
          bd_d    = is_eret ? cp0_cause[CA_BD] : mem_in_ds;
          rpc_d   = is_eret ? cp0_epc : EXC_VECTOR;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_REDIR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_REDIR: begin
        if (redir_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      epc_q   <= '0;
      badv_q  <= '0;
      rpc_q   <= '0;
      bd_q    <= 1'b0;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      badv_q  <= badv_d;
      rpc_q   <= rpc_d;
      bd_q    <= bd_d;
      eret_q  <= eret_d;
    end
  end

  assign exc_type    = {27'd0, exc_code};
  assign commit      = (state_q == S_FLUSH) && (cnt_q == 3'd0);
  assign flush       = (state_q == S_FLUSH);
  assign busy        = !idle;
  assign redir_valid = (state_q == S_REDIR);
  assign redir_pc    = rpc_q;
  assign commit_code = code_q;
  assign commit_epc  = epc_q;
  assign commit_bd   = bd_q;
  assign commit_badv = badv_q;
  assign commit_eret = eret_q;

  logic unused_inputs;
  assign unused_inputs = ^{cp0_status[31:16], cp0_status[7:2],
                           cp0_cause[30:10], cp0_cause[7:0], mem_except[1:0]};

endmodule
